// File: rtl/network_pkg.sv
// Types and constants shared by the network controller and its flash fetch path.
package network_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_HI = 2'd1,
    ACC_LO = 2'd2,
    DONE   = 2'd3
  } flash_rd_state_t;

  // Bytes fetched per weight/bias word.
  localparam int FLASH_WORD_BYTES  = 2;
  // Cycle at which networkController samples the fetched word.
  localparam int FLASH_WAIT_WINDOW = 11;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and terminal-count rollover.
// rollover_flag is high during the enabled cycle whose edge brings the
// count to rollover_val, so it can be used directly as a "last cycle" strobe.
// The count wraps to zero on that same edge.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] w_count_inc;

  assign w_count_inc   = count_out + 1'b1;
  assign rollover_flag = count_enable && (w_count_inc == rollover_val);

  // Count register: clear wins, then count and wrap at the terminal value.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= rollover_flag ? '0 : w_count_inc;
    end
  end

endmodule

// File: rtl/flash_word_reader.sv
// Fetches one big-endian 16-bit word from an 8-bit asynchronous parallel
// flash as two timed byte reads, for the network controller.
//
//   state  | meaning
//   IDLE   | waiting for flash_ready; flash deselected
//   ACC_HI | CE/OE low, byte address {word,0}; capture high byte on last cycle
//   ACC_LO | CE/OE low, byte address {word,1}; assemble word on last cycle
//   DONE   | data_valid pulse, flash deselected for one recovery cycle
module flash_word_reader
  import network_pkg::*;
#(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        flash_ready,
  input  logic [15:0] flash_address,
  output logic [15:0] flashData_out,
  output logic        data_valid,
  output logic        busy,
  output logic        req_overrun,
  output logic [16:0] fl_addr,
  output logic        fl_ce_n,
  output logic        fl_oe_n,
  input  logic [7:0]  fl_data
);

  localparam logic [2:0] ROLL_VAL = 3'(ACCESS_CYCLES);

  // Access time must fit the counter and leave the whole read inside the
  // controller's sampling window.
  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 4) begin : g_bad_access_cycles
    $error("flash_word_reader: ACCESS_CYCLES must be in 1..4");
  end
  if (FLASH_WORD_BYTES * ACCESS_CYCLES + 1 >= FLASH_WAIT_WINDOW) begin : g_bad_window
    $error("flash_word_reader: read latency exceeds controller wait window");
  end

  flash_rd_state_t r_state;
  flash_rd_state_t w_next_state;
  logic [15:0]     r_addr_q;
  logic [7:0]      r_hi_q;
  logic [15:0]     w_addr_next;
  logic [2:0]      w_wait_cnt;
  logic            w_last_cycle;
  logic            w_accept;
  logic            w_cnt_clear;
  logic            w_cnt_en;
  logic            w_access_next;

  assign w_accept    = (r_state == IDLE) && flash_ready;
  assign w_cnt_en    = (r_state == ACC_HI) || (r_state == ACC_LO);
  assign w_cnt_clear = w_accept || ((r_state == ACC_HI) && w_last_cycle);
  assign w_addr_next = w_accept ? flash_address : r_addr_q;

  assign busy       = (r_state != IDLE);
  assign data_valid = (r_state == DONE);

  flex_counter #(
    .NUM_CNT_BITS (3)
  ) u_wait_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_cnt_clear),
    .count_enable  (w_cnt_en),
    .rollover_val  (ROLL_VAL),
    .count_out     (w_wait_cnt),
    .rollover_flag (w_last_cycle)
  );

  // Next-state decode; the wait counter strobe ends each byte access.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (flash_ready)  w_next_state = ACC_HI;
      ACC_HI:  if (w_last_cycle) w_next_state = ACC_LO;
      ACC_LO:  if (w_last_cycle) w_next_state = DONE;
      DONE:                      w_next_state = IDLE;
      default:                   w_next_state = IDLE;
    endcase
  end

  assign w_access_next = (w_next_state == ACC_HI) || (w_next_state == ACC_LO);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latch, byte capture, word assembly and the sticky overrun flag.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_addr_q      <= '0;
      r_hi_q        <= '0;
      flashData_out <= '0;
      req_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr_q <= flash_address;
      end
      if ((r_state == ACC_HI) && w_last_cycle) begin
        r_hi_q <= fl_data;
      end
      if ((r_state == ACC_LO) && w_last_cycle) begin
        flashData_out <= {r_hi_q, fl_data};
      end
      if (flash_ready && (r_state != IDLE)) begin
        req_overrun <= 1'b1;
      end
    end
  end

  // Flash pins registered from the next state so they never glitch.
  // The address holds its last value while the flash is deselected.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fl_addr <= '0;
      fl_ce_n <= 1'b1;
      fl_oe_n <= 1'b1;
    end else begin
      fl_ce_n <= !w_access_next;
      fl_oe_n <= !w_access_next;
      if (w_next_state == ACC_HI) begin
        fl_addr <= {w_addr_next, 1'b0};
      end else if (w_next_state == ACC_LO) begin
        fl_addr <= {r_addr_q, 1'b1};
      end
    end
  end

  // The wait counter only runs during byte accesses, so it rests at zero in IDLE.
  always_ff @(posedge clk) begin
    if (n_rst && (r_state == IDLE)) begin
      assert (w_wait_cnt == 3'd0);
    end
  end

endmodule

// File: tb/tb_flash_word_reader.sv
// Bench for flash_word_reader: a behavioural flash byte model plus
// per-cycle expectations derived from the read timeline.
module tb_flash_word_reader;

  localparam int AC = 3;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        flash_ready;
  logic [15:0] flash_address;
  logic [15:0] flashData_out;
  logic        data_valid;
  logic        busy;
  logic        req_overrun;
  logic [16:0] fl_addr;
  logic        fl_ce_n;
  logic        fl_oe_n;
  logic [7:0]  fl_data;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_word;
  logic [7:0]  seed8;
  logic [16:0] ov_a [4];
  logic [7:0]  ov_d [4];
  int          model_ver = 0;

  flash_word_reader #(.ACCESS_CYCLES(AC)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .flash_ready   (flash_ready),
    .flash_address (flash_address),
    .flashData_out (flashData_out),
    .data_valid    (data_valid),
    .busy          (busy),
    .req_overrun   (req_overrun),
    .fl_addr       (fl_addr),
    .fl_ce_n       (fl_ce_n),
    .fl_oe_n       (fl_oe_n),
    .fl_data       (fl_data)
  );

  always #5 clk = ~clk;

  // Flash contents: a few pinned bytes, everything else a seeded pattern.
  function automatic logic [7:0] byte_of(input logic [16:0] a);
    for (int i = 0; i < 4; i++) begin
      if (ov_a[i] == a) return ov_d[i];
    end
    return a[7:0] ^ {a[14:8], a[16]} ^ {a[15], 7'h00} ^ seed8;
  endfunction

  // Asynchronous flash: drives its byte only while selected and output-enabled.
  always @(fl_addr, fl_ce_n, fl_oe_n, model_ver) begin
    fl_data = (!fl_ce_n && !fl_oe_n) ? byte_of(fl_addr) : 8'hEE;
  end

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if ({fl_ce_n, fl_oe_n, busy, data_valid} !== 4'b1100) begin
        failures++;
        $display("FAIL idle_ctrl got ce/oe/busy/dv=%b expected 1100", {fl_ce_n, fl_oe_n, busy, data_valid});
      end
      checks++;
      if (flashData_out !== exp_word) begin
        failures++;
        $display("FAIL idle_hold got %h expected %h", flashData_out, exp_word);
      end
    end
  endtask

  // One read: cycle 0 is the request cycle, sampled at each negedge.
  // inject_at pulses a second request in that cycle; abort_at resets mid-read.
  task automatic run_read(input logic [15:0] a, input int inject_at, input int abort_at);
    logic [15:0] w;
    logic [16:0] ea;
    logic [3:0]  ectl;
    logic [15:0] ed;
    w = {byte_of({a, 1'b0}), byte_of({a, 1'b1})};
    @(negedge clk);
    flash_ready   = 1'b1;
    flash_address = a;
    for (int k = 1; k <= 2 * AC + 1; k++) begin
      @(negedge clk);
      flash_ready = 1'b0;
      ectl = (k <= 2 * AC) ? 4'b0010 : 4'b1111;
      ea   = (k <= AC) ? {a, 1'b0} : {a, 1'b1};
      ed   = (k == 2 * AC + 1) ? w : exp_word;
      checks++;
      if ({fl_ce_n, fl_oe_n, busy, data_valid} !== ectl) begin
        failures++;
        $display("FAIL read_ctrl cyc=%0d got ce/oe/busy/dv=%b expected %b", k, {fl_ce_n, fl_oe_n, busy, data_valid}, ectl);
      end
      if (k <= 2 * AC) begin
        checks++;
        if (fl_addr !== ea) begin
          failures++;
          $display("FAIL read_addr cyc=%0d got %h expected %h", k, fl_addr, ea);
        end
      end
      checks++;
      if (flashData_out !== ed) begin
        failures++;
        $display("FAIL read_data cyc=%0d got %h expected %h", k, flashData_out, ed);
      end
      if (k == abort_at) begin
        #2 n_rst = 1'b0;
        #1;
        exp_word = 16'h0000;
        checks++;
        if ({fl_ce_n, fl_oe_n, busy, data_valid, req_overrun} !== 5'b11000) begin
          failures++;
          $display("FAIL abort_ctrl got ce/oe/busy/dv/ovr=%b expected 11000", {fl_ce_n, fl_oe_n, busy, data_valid, req_overrun});
        end
        checks++;
        if (flashData_out !== 16'h0000) begin
          failures++;
          $display("FAIL abort_data got %h expected 0000", flashData_out);
        end
        @(negedge clk);
        n_rst = 1'b1;
        return;
      end
      if (k == inject_at) begin
        flash_ready   = 1'b1;
        flash_address = ~a;
      end
    end
    exp_word = w;
  endtask

  task automatic test_reset();
    n_rst         = 1'b0;
    flash_ready   = 1'b0;
    flash_address = 16'h0000;
    exp_word      = 16'h0000;
    #12;
    checks++;
    if ({flashData_out, fl_addr, fl_ce_n, fl_oe_n, busy, data_valid, req_overrun} !== {16'h0, 17'h0, 5'b11000}) begin
      failures++;
      $display("FAIL reset_vals got data=%h addr=%h ce/oe/busy/dv/ovr=%b expected 0000 00000 11000",
               flashData_out, fl_addr, {fl_ce_n, fl_oe_n, busy, data_valid, req_overrun});
    end
    @(negedge clk);
    n_rst = 1'b1;
    idle_check(20);
  endtask

  task automatic test_known_word();
    ov_a[0] = 17'h0000A; ov_d[0] = 8'h12;
    ov_a[1] = 17'h0000B; ov_d[1] = 8'h34;
    model_ver++;
    run_read(16'h0005, 0, 0);
    checks++;
    if (flashData_out !== 16'h1234) begin
      failures++;
      $display("FAIL known_word got %h expected 1234", flashData_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_read(16'(i), 0, 0);
      idle_check(4);
    end
    checks++;
    if (req_overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_overrun got %b expected 0", req_overrun);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_read(16'($urandom), 0, 0);
      idle_check(int'($urandom_range(0, 3)));
    end
    checks++;
    if (req_overrun !== 1'b0) begin
      failures++;
      $display("FAIL rand_overrun got %b expected 0", req_overrun);
    end
  endtask

  task automatic test_overrun();
    run_read(16'($urandom), 3, 0);
    idle_check(AC + 2);
    checks++;
    if (req_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag got %b expected 1", req_overrun);
    end
  endtask

  task automatic test_top_address();
    ov_a[2] = 17'h1FFFE; ov_d[2] = 8'hAB;
    ov_a[3] = 17'h1FFFF; ov_d[3] = 8'hCD;
    model_ver++;
    run_read(16'hFFFF, 0, 0);
    checks++;
    if (flashData_out !== 16'hABCD) begin
      failures++;
      $display("FAIL top_word got %h expected abcd", flashData_out);
    end
    idle_check(2);
    checks++;
    if (req_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got %b expected 1", req_overrun);
    end
  endtask

  task automatic test_reset_mid_read();
    run_read(16'($urandom), 0, 5);
    run_read(16'h0002, 0, 0);
    idle_check(2);
    checks++;
    if (req_overrun !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_overrun got %b expected 0", req_overrun);
    end
  endtask

  initial begin
    seed8 = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      ov_a[i] = 17'h15555;
      ov_d[i] = 8'h00;
    end
    model_ver++;
    test_reset();
    test_known_word();
    test_back_to_back();
    test_random();
    test_overrun();
    test_top_address();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
